// File: rtl/wr_arbiter_if.sv
// Bus bundle between the AXI write-channel arbiter and the surrounding interconnect:
// master requests, muxed handshakes in, grant/select/enable steering out.
interface wr_arbiter_if #(
  parameter int CNT_BITS = 16
);
  logic                M0_AWValid;
  logic [31:0]         M0_AWAddr;
  logic                M1_AWValid;
  logic [31:0]         M1_AWAddr;
  logic                S_AWReady;
  logic                W_Valid;
  logic                W_Ready;
  logic                W_Last;
  logic                B_Valid;
  logic                B_Ready;
  logic [1:0]          M_grant;
  logic [2:0]          S_sel;
  logic                aw_en;
  logic                w_en;
  logic                b_en;
  logic                busy;
  logic [CNT_BITS-1:0] wr_cnt;

  // Interconnect side: drives requests and handshakes, observes the steering.
  modport master (
    output M0_AWValid, M0_AWAddr, M1_AWValid, M1_AWAddr,
    output S_AWReady, W_Valid, W_Ready, W_Last, B_Valid, B_Ready,
    input  M_grant, S_sel, aw_en, w_en, b_en, busy, wr_cnt
  );

  // Arbiter side.
  modport slave (
    input  M0_AWValid, M0_AWAddr, M1_AWValid, M1_AWAddr,
    input  S_AWReady, W_Valid, W_Ready, W_Last, B_Valid, B_Ready,
    output M_grant, S_sel, aw_en, w_en, b_en, busy, wr_cnt
  );
endinterface

// File: rtl/wr_arbiter.sv
// Round-robin write-channel arbiter: grants M0/M1, decodes the slave and holds
// the pairing through the AW, W and B phases of a single outstanding transaction.
module wr_arbiter #(
  parameter logic [31:0] S0_BASE  = 32'h0000_0000,
  parameter logic [31:0] S1_BASE  = 32'h0001_0000,
  parameter int          CNT_BITS = 16
) (
  input  logic        clk,
  input  logic        rst,
  wr_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AW   = 2'd1,
    ST_W    = 2'd2,
    ST_B    = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [1:0]          grant_r;
  logic [1:0]          grant_nxt_s;
  logic [2:0]          sel_r;
  logic [2:0]          sel_nxt_s;
  logic                last_m1_r;
  logic                last_m1_nxt_s;
  logic [CNT_BITS-1:0] cnt_r;
  logic [CNT_BITS-1:0] cnt_nxt_s;
  logic                aw_en_r;
  logic                w_en_r;
  logic                b_en_r;
  logic                busy_r;
  logic                pick_m1_s;
  logic                aw_valid_s;

  // 64 KiB regions: only the upper half-word of the address matters.
  function automatic logic [2:0] decode_slave(input logic [31:0] addr);
    logic [2:0] sel;
    if (addr[31:16] == S0_BASE[31:16]) begin
      sel = 3'b001;
    end else if (addr[31:16] == S1_BASE[31:16]) begin
      sel = 3'b010;
    end else begin
      sel = 3'b100;
    end
    return sel;
  endfunction

  assign aw_valid_s = grant_r[1] ? bus.M1_AWValid : bus.M0_AWValid;

  // Next-state, grant/select hold and completion bookkeeping.
  always_comb begin
    state_nxt_s   = state_r;
    grant_nxt_s   = grant_r;
    sel_nxt_s     = sel_r;
    last_m1_nxt_s = last_m1_r;
    cnt_nxt_s     = cnt_r;
    pick_m1_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        grant_nxt_s = 2'b00;
        sel_nxt_s   = 3'b000;
        if (bus.M0_AWValid || bus.M1_AWValid) begin
          // On a tie the master that did not win last time goes first.
          pick_m1_s   = (bus.M0_AWValid && bus.M1_AWValid) ? ~last_m1_r : bus.M1_AWValid;
          grant_nxt_s = pick_m1_s ? 2'b10 : 2'b01;
          sel_nxt_s   = decode_slave(pick_m1_s ? bus.M1_AWAddr : bus.M0_AWAddr);
          state_nxt_s = ST_AW;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_AW: begin
        if (aw_valid_s && bus.S_AWReady) begin
          state_nxt_s = ST_W;
        end else begin
          state_nxt_s = ST_AW;
        end
      end
      ST_W: begin
        if (bus.W_Valid && bus.W_Ready && bus.W_Last) begin
          state_nxt_s = ST_B;
        end else begin
          state_nxt_s = ST_W;
        end
      end
      ST_B: begin
        if (bus.B_Valid && bus.B_Ready) begin
          state_nxt_s   = ST_IDLE;
          grant_nxt_s   = 2'b00;
          sel_nxt_s     = 3'b000;
          last_m1_nxt_s = grant_r[1];
          cnt_nxt_s     = cnt_r + {{(CNT_BITS-1){1'b0}}, 1'b1};
        end else begin
          state_nxt_s = ST_B;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        grant_nxt_s = 2'b00;
        sel_nxt_s   = 3'b000;
      end
    endcase
  end

  // State and registered outputs; enables come from the next state so they have no input-to-output path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      grant_r   <= 2'b00;
      sel_r     <= 3'b000;
      last_m1_r <= 1'b1;
      cnt_r     <= {CNT_BITS{1'b0}};
      aw_en_r   <= 1'b0;
      w_en_r    <= 1'b0;
      b_en_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      grant_r   <= grant_nxt_s;
      sel_r     <= sel_nxt_s;
      last_m1_r <= last_m1_nxt_s;
      cnt_r     <= cnt_nxt_s;
      aw_en_r   <= (state_nxt_s == ST_AW);
      w_en_r    <= (state_nxt_s == ST_W);
      b_en_r    <= (state_nxt_s == ST_B);
      busy_r    <= (state_nxt_s != ST_IDLE);
    end
  end

  assign bus.M_grant = grant_r;
  assign bus.S_sel   = sel_r;
  assign bus.aw_en   = aw_en_r;
  assign bus.w_en    = w_en_r;
  assign bus.b_en    = b_en_r;
  assign bus.busy    = busy_r;
  assign bus.wr_cnt  = cnt_r;

endmodule
